// File: rtl/median_pkg.sv
// Shared definitions for the median window address scanner: FSM state
// encoding and window-geometry helpers (radius and tap count).
package median_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

    // Window radius R = (WIN-1)/2 for an odd window side length.
    function automatic int unsigned win_radius(input int unsigned win);
        return (win - 1) / 2;
    endfunction

    // Number of taps in one window (WIN*WIN).
    function automatic int unsigned win_taps(input int unsigned win);
        return win * win;
    endfunction

    localparam int unsigned DEFAULT_WIN  = 3;
    localparam int unsigned DEFAULT_R    = (DEFAULT_WIN - 1) / 2;
    localparam int unsigned DEFAULT_TAPS = DEFAULT_WIN * DEFAULT_WIN;

endpackage

// File: rtl/median_axis_counter.sv
// Loadable wrap-around counter used for each scan axis (dx, dy, center x,
// center y). Counts min..max, wraps to min, and flags the last value.
module median_axis_counter #(
    parameter int unsigned W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] min_i,
    input  logic [W-1:0] max_i,
    output logic [W-1:0] value_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load takes priority, otherwise step and wrap at max.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = min_i;
        end else if (en_i) begin
            if (cnt_q == max_i) begin
                cnt_d = min_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count register, reset to the axis' first value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;
    assign wrap_o  = (cnt_q == max_i);

endmodule

// File: rtl/median_window_scanner.sv
// Median window scanner: walks every window center of the image and emits
// the WIN*WIN tap addresses of each window with a valid/ready handshake.
// Optional build macro: MEDIAN_BORDER_CLAMP_EN -- scan every pixel as a
// center and clamp out-of-image taps to the border; without it only
// interior centers are scanned and no clamping logic exists.
module median_window_scanner
    import median_pkg::*;
#(
    parameter int unsigned IMG_W   = 64,
    parameter int unsigned IMG_H   = 64,
    parameter int unsigned WIN     = 3,
    parameter int unsigned COORD_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               ready,
    output logic [COORD_W-1:0] xWindowAddress,
    output logic [COORD_W-1:0] yWindowAddress,
    output logic               addrValid,
    output logic [COORD_W-1:0] xWindowCenter,
    output logic [COORD_W-1:0] yWindowCenter,
    output logic               windowLast,
    output logic               imageDone,
    output logic               busy
);

    localparam int unsigned R = win_radius(WIN);

`ifdef MEDIAN_BORDER_CLAMP_EN
    localparam int unsigned CX_MIN = 0;
    localparam int unsigned CX_MAX = IMG_W - 1;
    localparam int unsigned CY_MIN = 0;
    localparam int unsigned CY_MAX = IMG_H - 1;
`else
    localparam int unsigned CX_MIN = R;
    localparam int unsigned CX_MAX = IMG_W - 1 - R;
    localparam int unsigned CY_MIN = R;
    localparam int unsigned CY_MAX = IMG_H - 1 - R;
`endif

    localparam logic [COORD_W-1:0] CX_MIN_C = COORD_W'(CX_MIN);
    localparam logic [COORD_W-1:0] CX_MAX_C = COORD_W'(CX_MAX);
    localparam logic [COORD_W-1:0] CY_MIN_C = COORD_W'(CY_MIN);
    localparam logic [COORD_W-1:0] CY_MAX_C = COORD_W'(CY_MAX);
    localparam logic [COORD_W-1:0] D_MAX_C  = COORD_W'(WIN - 1);

    scan_state_e state_q;
    scan_state_e state_d;

    logic               valid;
    logic               accept;
    logic               start_load;
    logic               dx_en, dy_en, cx_en, cy_en;
    logic               dx_wrap, dy_wrap, cx_wrap, cy_wrap;
    logic               scan_end;
    logic [COORD_W-1:0] dx_idx, dy_idx, cx_val, cy_val;
    logic [COORD_W-1:0] tap_x, tap_y;

    assign valid      = (state_q == ST_SCAN);
    assign accept     = valid && ready;
    assign start_load = (state_q == ST_IDLE) && start;

    // Nested enables: dx fastest, then dy, then center x, then center y.
    assign dx_en    = accept;
    assign dy_en    = dx_en && dx_wrap;
    assign cx_en    = dy_en && dy_wrap;
    assign cy_en    = cx_en && cx_wrap;
    assign scan_end = cy_en && cy_wrap;

    median_axis_counter #(.W(COORD_W), .RST_VAL('0)) u_dx (
        .clk(clk), .rst_n(reset), .load_i(start_load), .en_i(dx_en),
        .min_i('0), .max_i(D_MAX_C), .value_o(dx_idx), .wrap_o(dx_wrap)
    );

    median_axis_counter #(.W(COORD_W), .RST_VAL('0)) u_dy (
        .clk(clk), .rst_n(reset), .load_i(start_load), .en_i(dy_en),
        .min_i('0), .max_i(D_MAX_C), .value_o(dy_idx), .wrap_o(dy_wrap)
    );

    median_axis_counter #(.W(COORD_W), .RST_VAL(CX_MIN_C)) u_cx (
        .clk(clk), .rst_n(reset), .load_i(start_load), .en_i(cx_en),
        .min_i(CX_MIN_C), .max_i(CX_MAX_C), .value_o(cx_val), .wrap_o(cx_wrap)
    );

    median_axis_counter #(.W(COORD_W), .RST_VAL(CY_MIN_C)) u_cy (
        .clk(clk), .rst_n(reset), .load_i(start_load), .en_i(cy_en),
        .min_i(CY_MIN_C), .max_i(CY_MAX_C), .value_o(cy_val), .wrap_o(cy_wrap)
    );

`ifdef MEDIAN_BORDER_CLAMP_EN
    logic signed [COORD_W:0] tap_x_s, tap_y_s;

    // Signed tap position, then clamp to the image border.
    always_comb begin
        tap_x_s = $signed({1'b0, cx_val}) + $signed({1'b0, dx_idx})
                  - $signed((COORD_W+1)'(R));
        tap_y_s = $signed({1'b0, cy_val}) + $signed({1'b0, dy_idx})
                  - $signed((COORD_W+1)'(R));
        tap_x = tap_x_s[COORD_W-1:0];
        tap_y = tap_y_s[COORD_W-1:0];
        if (tap_x_s < 0) begin
            tap_x = '0;
        end else if (tap_x_s > $signed((COORD_W+1)'(IMG_W - 1))) begin
            tap_x = COORD_W'(IMG_W - 1);
        end
        if (tap_y_s < 0) begin
            tap_y = '0;
        end else if (tap_y_s > $signed((COORD_W+1)'(IMG_H - 1))) begin
            tap_y = COORD_W'(IMG_H - 1);
        end
    end
`else
    // Interior centers keep every tap inside the image, so the sign bit of
    // the widened sum is always zero and the sum is formed at COORD_W bits.
    always_comb begin
        tap_x = cx_val + dx_idx - COORD_W'(R);
        tap_y = cy_val + dy_idx - COORD_W'(R);
    end
`endif

    // Scan sequencing: IDLE -> SCAN on start, SCAN -> DONE on final tap.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_SCAN;
            ST_SCAN: if (scan_end) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign addrValid      = valid;
    assign xWindowAddress = valid ? tap_x  : '0;
    assign yWindowAddress = valid ? tap_y  : '0;
    assign xWindowCenter  = valid ? cx_val : '0;
    assign yWindowCenter  = valid ? cy_val : '0;
    assign windowLast     = valid && dx_wrap && dy_wrap;
    assign imageDone      = (state_q == ST_DONE);
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_median_window_scanner.sv
// Self-checking bench for median_window_scanner on an 8x6 image: a WIN=3
// instance (start pulse, backpressure, mid-scan reset, held start) and a
// WIN=5 instance. Honours MEDIAN_BORDER_CLAMP_EN when defined.
module tb_median_window_scanner;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int CW = 8;
`ifdef MEDIAN_BORDER_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif
    localparam int A_FIRST_C = CLAMP ? 0 : 1;
    localparam int A_LAST_CX = CLAMP ? 7 : 6;
    localparam int A_LAST_CY = CLAMP ? 5 : 4;
    localparam int B_FIRST_C = CLAMP ? 0 : 2;
    localparam int B_LAST_CX = CLAMP ? 7 : 5;
    localparam int B_LAST_CY = CLAMP ? 5 : 3;

    logic clk = 1'b0;
    logic reset;
    logic start_a, ready_a, start_b, ready_b;

    logic [CW-1:0] xa_a, ya_a, xc_a, yc_a;
    logic          av_a, wl_a, dn_a, bz_a;
    logic [CW-1:0] xa_b, ya_b, xc_b, yc_b;
    logic          av_b, wl_b, dn_b, bz_b;

    int checks   = 0;
    int failures = 0;
    int ka = 0, kb = 0;
    bit done_exp_a = 0, done_exp_b = 0;

    always #5 clk = ~clk;

    median_window_scanner #(.IMG_W(W), .IMG_H(H), .WIN(3), .COORD_W(CW)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .ready(ready_a),
        .xWindowAddress(xa_a), .yWindowAddress(ya_a), .addrValid(av_a),
        .xWindowCenter(xc_a), .yWindowCenter(yc_a), .windowLast(wl_a),
        .imageDone(dn_a), .busy(bz_a)
    );

    median_window_scanner #(.IMG_W(W), .IMG_H(H), .WIN(5), .COORD_W(CW)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .ready(ready_b),
        .xWindowAddress(xa_b), .yWindowAddress(ya_b), .addrValid(av_b),
        .xWindowCenter(xc_b), .yWindowCenter(yc_b), .windowLast(wl_b),
        .imageDone(dn_b), .busy(bz_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Tap k of a whole scan, from window index and tap-within-window.
    function automatic void model_tap(input int win, input int k,
                                      output int ex, output int ey,
                                      output int ecx, output int ecy, output int ewl);
        int r, taps, wnd, t, cmin, ncx;
        r    = (win - 1) / 2;
        taps = win * win;
        wnd  = k / taps;
        t    = k % taps;
        cmin = CLAMP ? 0 : r;
        ncx  = CLAMP ? W : W - 2 * r;
        ecx  = cmin + wnd % ncx;
        ecy  = cmin + wnd / ncx;
        ex   = ecx + t % win - r;
        ey   = ecy + t / win - r;
        if (CLAMP) begin
            if (ex < 0) ex = 0;
            if (ex > W - 1) ex = W - 1;
            if (ey < 0) ey = 0;
            if (ey > H - 1) ey = H - 1;
        end
        ewl = (t == taps - 1) ? 1 : 0;
    endfunction

    function automatic int model_total(input int win);
        int r;
        r = (win - 1) / 2;
        if (CLAMP) return W * H * win * win;
        return (W - 2 * r) * (H - 2 * r) * win * win;
    endfunction

    // Compare process for the WIN=3 instance.
    always @(negedge clk) begin
        int ex, ey, ecx, ecy, ewl;
        if (!reset) begin
            ka = 0;
            done_exp_a = 0;
            check("a_rst_valid", av_a, 0);
            check("a_rst_done", dn_a, 0);
            check("a_rst_busy", bz_a, 0);
            check("a_rst_last", wl_a, 0);
            check("a_rst_addr", {xa_a, ya_a, xc_a, yc_a}, 0);
        end else begin
            check("a_done", dn_a, done_exp_a);
            if (done_exp_a) check("a_valid_in_done", av_a, 0);
            done_exp_a = 0;
            if (av_a) begin
                model_tap(3, ka, ex, ey, ecx, ecy, ewl);
                check("a_x", xa_a, ex);
                check("a_y", ya_a, ey);
                check("a_cx", xc_a, ecx);
                check("a_cy", yc_a, ecy);
                check("a_last", wl_a, ewl);
                if (ready_a) begin
                    ka++;
                    if (ka == model_total(3)) begin
                        ka = 0;
                        done_exp_a = 1;
                    end
                end
            end
        end
    end

    // Compare process for the WIN=5 instance.
    always @(negedge clk) begin
        int ex, ey, ecx, ecy, ewl;
        if (!reset) begin
            kb = 0;
            done_exp_b = 0;
            check("b_rst_valid", av_b, 0);
        end else begin
            check("b_done", dn_b, done_exp_b);
            if (done_exp_b) check("b_valid_in_done", av_b, 0);
            done_exp_b = 0;
            if (av_b) begin
                model_tap(5, kb, ex, ey, ecx, ecy, ewl);
                check("b_x", xa_b, ex);
                check("b_y", ya_b, ey);
                check("b_cx", xc_b, ecx);
                check("b_cy", yc_b, ecy);
                check("b_last", wl_b, ewl);
                if (ready_b) begin
                    kb++;
                    if (kb == model_total(5)) begin
                        kb = 0;
                        done_exp_b = 1;
                    end
                end
            end
        end
    end

    task automatic wait_ka(input int n);
        int c = 0;
        while (ka != n && c < 5000) begin
            @(posedge clk); #1;
            c++;
        end
        check("a_wait_tap", (ka == n) ? 1 : 0, 1);
    endtask

    task automatic wait_done_a();
        int c = 0;
        bit seen = 0;
        while (!dn_a && c < 10000) begin
            if (av_a && ka == model_total(3) - 1 && !seen) begin
                seen = 1;
                check("a_last_x", xa_a, 7);
                check("a_last_y", ya_a, 5);
                check("a_last_cx", xc_a, A_LAST_CX);
                check("a_last_cy", yc_a, A_LAST_CY);
                check("a_last_wl", wl_a, 1);
            end
            @(posedge clk); #1;
            c++;
        end
        check("a_done_seen", dn_a, 1);
        check("a_last_seen", seen, 1);
        check("a_done_busy", bz_a, 1);
    endtask

    task automatic wait_done_b();
        int c = 0;
        bit seen = 0;
        while (!dn_b && c < 10000) begin
            if (av_b && kb == model_total(5) - 1 && !seen) begin
                seen = 1;
                check("b_last_x", xa_b, 7);
                check("b_last_y", ya_b, 5);
                check("b_last_cx", xc_b, B_LAST_CX);
                check("b_last_cy", yc_b, B_LAST_CY);
            end
            @(posedge clk); #1;
            c++;
        end
        check("b_done_seen", dn_b, 1);
        check("b_last_seen", seen, 1);
    endtask

    initial begin
        int ex, ey, ecx, ecy, ewl;
        logic [CW-1:0] hx, hy, hcx, hcy;
        logic hwl;

        reset = 1'b1;
        start_a = 0; ready_a = 1; start_b = 0; ready_b = 1;
        #1 reset = 1'b0;

        // Model pins against hand-computed values.
        model_tap(3, 0, ex, ey, ecx, ecy, ewl);
        check("model_first", {ex[7:0], ey[7:0], ecx[7:0], ecy[7:0]},
              {8'd0, 8'd0, 8'(A_FIRST_C), 8'(A_FIRST_C)});
        model_tap(3, model_total(3) - 1, ex, ey, ecx, ecy, ewl);
        check("model_last", {ex[7:0], ey[7:0], ecx[7:0], ecy[7:0]},
              {8'd7, 8'd5, 8'(A_LAST_CX), 8'(A_LAST_CY)});
        check("model_total3", model_total(3), CLAMP ? 432 : 216);
        check("model_total5", model_total(5), CLAMP ? 1200 : 200);
        model_tap(5, 24, ex, ey, ecx, ecy, ewl);
        check("model_wl25", ewl, 1);
        model_tap(5, 23, ex, ey, ecx, ecy, ewl);
        check("model_wl24", ewl, 0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bz_a, 0);
        check("rst_valid", av_a, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Start pulse with backpressure at tap 5.
        check("idle_valid", av_a, 0);
        start_a = 1;
        @(posedge clk); #1;
        start_a = 0;
        check("first_valid", av_a, 1);
        check("first_busy", bz_a, 1);
        check("first_xy", {xa_a, ya_a}, 0);
        check("first_cx", xc_a, A_FIRST_C);
        check("first_cy", yc_a, A_FIRST_C);
        wait_ka(5);
        ready_a = 0;
        hx = xa_a; hy = ya_a; hcx = xc_a; hcy = yc_a; hwl = wl_a;
        repeat (3) begin
            @(posedge clk); #1;
            check("stall_hold", {xa_a, ya_a, xc_a, yc_a, 7'd0, hwl},
                  {hx, hy, hcx, hcy, 7'd0, wl_a});
            check("stall_valid", av_a, 1);
            check("stall_tap", ka, 5);
        end
        ready_a = 1;
        wait_done_a();
        @(posedge clk); #1;
        check("after_done_busy", bz_a, 0);
        check("after_done_pulse", dn_a, 0);

        // Reset in the middle of a scan.
        start_a = 1;
        @(posedge clk); #1;
        start_a = 0;
        wait_ka(100);
        reset = 1'b0;
        #1;
        check("midrst_valid", av_a, 0);
        check("midrst_busy", bz_a, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_no_done", dn_a, 0);
        start_a = 1;
        @(posedge clk); #1;
        start_a = 0;
        check("restart_valid", av_a, 1);
        check("restart_xy", {xa_a, ya_a}, 0);
        wait_done_a();
        @(posedge clk); #1;

        // Start held high: one scan, then an immediate second one.
        start_a = 1;
        @(posedge clk); #1;
        check("held_valid", av_a, 1);
        wait_done_a();
        @(posedge clk); #1;
        check("held_idle_valid", av_a, 0);
        check("held_idle_busy", bz_a, 0);
        @(posedge clk); #1;
        check("held_second_valid", av_a, 1);
        check("held_second_xy", {xa_a, ya_a}, 0);
        start_a = 0;
        wait_done_a();
        @(posedge clk); #1;

        // WIN=5 instance.
        start_b = 1;
        @(posedge clk); #1;
        start_b = 0;
        check("b_first_valid", av_b, 1);
        check("b_first_xy", {xa_b, ya_b}, 0);
        check("b_first_c", {xc_b, yc_b}, {8'(B_FIRST_C), 8'(B_FIRST_C)});
        wait_done_b();
        @(posedge clk); #1;
        check("b_after_busy", bz_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
